// File: rtl/round_timer_ctrl.sv
// Per-round countdown controller for the binary math game.
// Drives the enable/clear of the 1 ms / 100 ms / 1 s tick chain and
// counts the round's remaining seconds from its one-second tick.
module round_timer_ctrl #(
   parameter int unsigned WIDTH           = 8,
   parameter int unsigned DEFAULT_SECONDS = 30,
   parameter int unsigned WARN_THRESHOLD  = 5
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Start,
   input  logic             Pause,
   input  logic             Answered,
   input  logic [WIDTH-1:0] LoadSeconds,
   input  logic             OneSecondTick,
   output logic             TickEnable,
   output logic             TickClear,
   output logic [WIDTH-1:0] SecondsLeft,
   output logic             TimeUp,
   output logic             Running,
   output logic             Warning,
   output logic [1:0]       StateOut
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      PAUSED  = 2'd2,
      EXPIRED = 2'd3
   } stateT;

   localparam logic [WIDTH-1:0] DefaultLoad = WIDTH'(DEFAULT_SECONDS);
   localparam logic [WIDTH-1:0] WarnLevel   = WIDTH'(WARN_THRESHOLD);
   localparam logic [WIDTH-1:0] OneSecond   = WIDTH'(1);

   stateT state;

   // Round sequencing: Start > Answered > tick > Pause, all outputs registered
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state       <= IDLE;
         SecondsLeft <= '0;
         TickEnable  <= 1'b0;
         TickClear   <= 1'b0;
         TimeUp      <= 1'b0;
         Running     <= 1'b0;
      end else begin
         TickClear <= 1'b0;
         TimeUp    <= 1'b0;
         if (Start) begin
            SecondsLeft <= (LoadSeconds == '0) ? DefaultLoad : LoadSeconds;
            TickClear   <= 1'b1;
            TickEnable  <= 1'b1;
            Running     <= 1'b1;
            state       <= RUN;
         end else begin
            unique case (state)
               RUN: begin
                  if (Answered) begin
                     // SecondsLeft is kept for scoring
                     state      <= IDLE;
                     TickEnable <= 1'b0;
                     Running    <= 1'b0;
                  end else if (OneSecondTick && SecondsLeft == OneSecond) begin
                     // Expiry takes precedence over a coincident Pause
                     SecondsLeft <= '0;
                     TimeUp      <= 1'b1;
                     state       <= EXPIRED;
                     TickEnable  <= 1'b0;
                     Running     <= 1'b0;
                  end else begin
                     // A non-expiring tick still lands when Pause coincides
                     if (OneSecondTick && SecondsLeft > OneSecond)
                        SecondsLeft <= SecondsLeft - OneSecond;
                     if (Pause) begin
                        state      <= PAUSED;
                        TickEnable <= 1'b0;
                        Running    <= 1'b0;
                     end
                  end
               end
               PAUSED: begin
                  if (Answered) begin
                     state <= IDLE;
                  end else if (Pause) begin
                     // Resume without TickClear keeps the partial second
                     state      <= RUN;
                     TickEnable <= 1'b1;
                     Running    <= 1'b1;
                  end
               end
               EXPIRED: begin
                  state <= EXPIRED;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

   // Warning is decoded from registered values only
   always_comb begin
      Warning  = Running && (SecondsLeft <= WarnLevel);
      StateOut = state;
   end

endmodule

// File: doc/round_timer_ctrl.md
Name: round_timer_ctrl

Overview:
Per-round countdown controller for the binary math game. It sequences the one-second tick generator chain: enables it, clears it at round start, and pauses it. It consumes the one-second tick to count down the round's remaining seconds and signals timeout to the game FSM. It sits between the game control FSM and the 1 ms / 100 ms / 1 s tick generator.

Parameters:
WIDTH, 8, width of the seconds counter and load value
DEFAULT_SECONDS, 30, reload value used when LoadSeconds is 0
WARN_THRESHOLD, 5, Warning asserts while running with SecondsLeft <= this value

Ports:
Clock  input  1  system clock
Reset  input  1  asynchronous, active-high reset
Start  input  1  single-cycle pulse; start or restart a round
Pause  input  1  single-cycle pulse; toggle between RUN and PAUSED
Answered  input  1  single-cycle pulse; player answered, stop the round
LoadSeconds  input  WIDTH  round length, sampled only on an accepted Start
OneSecondTick  input  1  single-cycle pulse from the tick generator
TickEnable  output  1  enable to the tick generator
TickClear  output  1  one-cycle reset pulse to the tick generator
SecondsLeft  output  WIDTH  remaining seconds
TimeUp  output  1  one-cycle pulse on expiry
Running  output  1  high in RUN
Warning  output  1  Running && SecondsLeft <= WARN_THRESHOLD
StateOut  output  2  IDLE=0, RUN=1, PAUSED=2, EXPIRED=3

Behaviour:
- All outputs are registered, except Warning, which is decoded from registered values.
- Reset (async) values: state=IDLE, SecondsLeft=0, TickEnable=0, TickClear=0, TimeUp=0, Running=0.
- Accepted Start:
  - In any state, load SecondsLeft = (LoadSeconds==0 ? DEFAULT_SECONDS : LoadSeconds).
  - TickClear=1 for exactly the next cycle.
  - Go to RUN.
  - TickEnable=1 from the next cycle.
  - The first tick therefore follows a full second.
- RUN, TickEnable=1. Per-cycle priority is Start > Answered > tick > Pause:
  - Answered: go to IDLE. SecondsLeft is held for scoring. Any coincident tick is ignored.
  - Tick with SecondsLeft > 1: decrement by 1.
  - Tick with SecondsLeft == 1: SecondsLeft becomes 0, TimeUp pulses next cycle, go to EXPIRED. Expiry wins over a coincident Pause.
  - Pause with no expiry: go to PAUSED. A coincident non-expiring tick is still applied.
- PAUSED, TickEnable=0:
  - Ticks are ignored.
  - Pause: return to RUN with no TickClear, so the partial second accumulated in the generator is preserved.
  - Answered: go to IDLE.
- EXPIRED, TickEnable=0:
  - SecondsLeft holds 0.
  - TimeUp fires exactly once per expiry.
  - Only Start leaves this state.
- IDLE, TickEnable=0:
  - Pause, Answered and ticks are ignored.
  - SecondsLeft holds its last value.
- SecondsLeft never wraps below 0. A tick with SecondsLeft==0 in RUN cannot occur; treat it as a no-op.
- Reset mid-round: everything returns immediately to reset values, and TickEnable drops asynchronously.
- Latency:
  - Start to TickEnable/Running high: 1 cycle.
  - Tick to SecondsLeft update: 1 cycle.
  - Final tick to TimeUp: 1 cycle.

Test Plan:
- Reset, Start with LoadSeconds=3, three ticks → TickClear high for 1 cycle; SecondsLeft 3→2→1→0; TimeUp single pulse one cycle after the 3rd tick; StateOut=3; TickEnable=0.
- Start with LoadSeconds=0 → SecondsLeft=30. Tick down to 5 → Warning rises when SecondsLeft=5 and stays high through expiry-1.
- Start with LoadSeconds=10, two ticks, Pause, three ticks, Pause, one tick → SecondsLeft=7; TickEnable low during the pause; no TickClear on resume.
- Start with LoadSeconds=4, Answered on the same cycle as a tick → StateOut=0; SecondsLeft=4 held; no TimeUp.
- SecondsLeft=1 with tick and Pause coincident → EXPIRED, TimeUp=1. Then Start with LoadSeconds=9 → RUN, SecondsLeft=9.
- Reset asserted mid-RUN with SecondsLeft=6 → SecondsLeft=0, TickEnable=0 immediately (async); StateOut=0 after release.
